rst_seq: RTL and testbench

Reset sequencer that originates the design's resets. It merges three reset sources: the asynchronous board reset, a debounced push-button, and a synchronous software request. It drives two staged, registered reset outputs: core domain first, peripherals after a fixed gap. Assertion of `reset` takes effect immediately; every other assertion and every release is synchronous to `clk`.

---
 rtl/rst_seq.sv | 171 +++++++++++++++++
 tb/tb_rst_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq.sv
// -----------------------------------------------------------------------------
// rst_seq -- reset sequencer that originates the design's resets.
//
// This block merges three reset sources:
//   - the asynchronous board reset;
//   - a debounced push-button;
//   - a synchronous software request.
// It releases two staged reset domains: core first, then peripherals after a
// fixed gap.
//
// Assertion of `reset` takes effect immediately. Every other assertion, and
// every release, happens on a rising edge of `clk`.
//
// Parameters
//   HOLD_CYCLES      cycles both resets stay high before core release (>= 2)
//   STAGE_GAP        cycles between core release and peripheral release (>= 1)
//   DEBOUNCE_CYCLES  consecutive synchronized high samples for a press (>= 1)
//
// Ports
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   btn_raw     in   raw push-button, active-high, unsynchronized
//   sw_req      in   synchronous software reset request, active-high
//   rst_core    out  core reset, active-high, registered
//   rst_periph  out  peripheral reset, active-high, registered
//   rst_active  out  high in every state except RUN
//   cause       out  last reset source: 00 external, 01 software, 10 button
// -----------------------------------------------------------------------------
module rst_seq #(
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGE_GAP       = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       sw_req,
    output logic       rst_core,
    output logic       rst_periph,
    output logic       rst_active,
    output logic [1:0] cause
);

    localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    // The state encoding is {core reset, peripheral reset}. With this encoding
    // each reset output is a flop output directly, so the outputs cannot glitch.
    localparam logic [1:0] ST_HOLD = 2'b11;
    localparam logic [1:0] ST_CORE = 2'b01;
    localparam logic [1:0] ST_RUN  = 2'b00;

    localparam logic [1:0] CAUSE_EXT = 2'b00;
    localparam logic [1:0] CAUSE_SW  = 2'b01;
    localparam logic [1:0] CAUSE_BTN = 2'b10;

    logic             rel_q1, rel_q2;
    logic             btn_s1, btn_s2;
    logic [DB_W-1:0]  db_cnt;
    logic             armed;
    logic             btn_evt;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;

    // Release synchronizer.
    // Assertion of `reset` is asynchronous. Its removal reaches the FSM only
    // after two edges, so the FSM never leaves HOLD on a metastable release.
    // NOTE: sequential state uses non-blocking (<=) assignments so that every
    // flop samples its pre-edge value; blocking here would collapse the
    // two-stage chain into one flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rel_q1 <= 1'b0;
            rel_q2 <= 1'b0;
        end else begin
            rel_q1 <= 1'b1;
            rel_q2 <= rel_q1;
        end
    end

    // Button path: two-flop synchronizer, then the debounce counter.
    // The counter saturates at DEBOUNCE_CYCLES-1. `armed` allows only one
    // event per press and is set again once the button is released.
    assign btn_evt = btn_s2 && armed && (db_cnt == DB_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            db_cnt <= '0;
            armed  <= 1'b1;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            if (!btn_s2) begin
                db_cnt <= '0;
                armed  <= 1'b1;
            end else begin
                if (db_cnt != DB_LAST)
                    db_cnt <= db_cnt + DB_W'(1);
                if (btn_evt)
                    armed <= 1'b0;
            end
        end
    end

    // Sequencer next-state logic. A request beats the count transitions.
    // A request taken in HOLD restarts the count, which extends the hold.
    // NOTE: every variable gets a default at the top of the combinational
    // block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        cause_d = cause_q;
        if (!rel_q2) begin
            cnt_d = cnt_q;
        end else if (sw_req || btn_evt) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            cause_d = btn_evt ? CAUSE_BTN : CAUSE_SW;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_CORE;
                        cnt_d   = '0;
                    end
                end
                ST_CORE: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
                ST_RUN: begin
                    cnt_d = '0;
                end
                default: begin
                    // The unused encoding falls back to a full reset hold.
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            cause_q <= CAUSE_EXT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    assign rst_core   = state_q[1];
    assign rst_periph = state_q[0];
    assign rst_active = state_q[0];
    assign cause      = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_rst_seq -- self-checking bench for rst_seq at its default parameters
// (16 / 8 / 4).
//
// Edges are numbered from the first rising edge after `reset` is released.
// Each scenario task queues the output vector expected after given edges.
// The vector is {rst_core, rst_periph, rst_active, cause}. The task then runs
// the clock, drives its stimulus on falling edges, and compares each queued
// entry when its edge has been reached.
// -----------------------------------------------------------------------------
module tb_rst_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_raw = 1'b0;
    logic       sw_req = 1'b0;
    logic       rst_core, rst_periph, rst_active;
    logic [1:0] cause;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    typedef struct {
        int         at_edge;
        logic [4:0] vec;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    // Expected vectors {core, periph, active, cause}.
    localparam logic [4:0] HOLD_EXT = 5'b111_00;
    localparam logic [4:0] HOLD_SW  = 5'b111_01;
    localparam logic [4:0] HOLD_BTN = 5'b111_10;
    localparam logic [4:0] CORE_EXT = 5'b011_00;
    localparam logic [4:0] CORE_SW  = 5'b011_01;
    localparam logic [4:0] CORE_BTN = 5'b011_10;
    localparam logic [4:0] RUN_EXT  = 5'b000_00;
    localparam logic [4:0] RUN_SW   = 5'b000_01;
    localparam logic [4:0] RUN_BTN  = 5'b000_10;

    wire [4:0] obs = {rst_core, rst_periph, rst_active, cause};

    rst_seq dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .sw_req     (sw_req),
        .rst_core   (rst_core),
        .rst_periph (rst_periph),
        .rst_active (rst_active),
        .cause      (cause)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    function automatic void want(int at_edge, logic [4:0] vec, string name);
        exp_q.push_back('{at_edge, vec, name});
    endfunction

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== HOLD_EXT) begin
            errors++;
            $display("FAIL por_values: got %b expected %b", obs, HOLD_EXT);
        end
        want(17, HOLD_EXT, "por_hold_17");
        want(18, CORE_EXT, "por_core_18");
        want(25, CORE_EXT, "por_core_25");
        want(26, RUN_EXT,  "por_run_26");
        reset = 1'b0;
        for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].at_edge <= edge_cnt) begin
                e = exp_q.pop_front();
                checks++;
                if (e.at_edge != edge_cnt || obs !== e.vec) begin
                    errors++;
                    $display("FAIL %s: edge %0d got %b expected %b", e.name, edge_cnt, obs, e.vec);
                end
            end
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL por_timeout: %0d expectations left", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_sw_req();
        exp_t e;
        want(39, RUN_EXT,  "sw_before_39");
        want(40, HOLD_SW,  "sw_hold_40");
        want(55, HOLD_SW,  "sw_hold_55");
        want(56, CORE_SW,  "sw_core_56");
        want(63, CORE_SW,  "sw_core_63");
        want(64, RUN_SW,   "sw_run_64");
        for (int cyc = 0; cyc < 60 && exp_q.size() > 0; cyc++) begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].at_edge <= edge_cnt) begin
                e = exp_q.pop_front();
                checks++;
                if (e.at_edge != edge_cnt || obs !== e.vec) begin
                    errors++;
                    $display("FAIL %s: edge %0d got %b expected %b", e.name, edge_cnt, obs, e.vec);
                end
            end
            sw_req = (edge_cnt == 39);
        end
        sw_req = 1'b0;
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL sw_timeout: %0d expectations left", exp_q.size());
            exp_q.delete();
        end
    endtask

    // The glitch is sampled at edges 71..73 and must do nothing. The press is
    // sampled from edge 100 and held past edge 129, so the whole release
    // sequence finishes while the button is still down.
    task automatic test_button();
        exp_t e;
        want(76,  RUN_SW,   "glitch_76");
        want(80,  RUN_SW,   "glitch_80");
        want(104, RUN_SW,   "btn_before_104");
        want(105, HOLD_BTN, "btn_hold_105");
        want(120, HOLD_BTN, "btn_hold_120");
        want(121, CORE_BTN, "btn_core_121");
        want(128, CORE_BTN, "btn_core_128");
        want(129, RUN_BTN,  "btn_run_129");
        want(138, RUN_BTN,  "btn_held_138");
        want(145, RUN_BTN,  "btn_single_145");
        for (int cyc = 0; cyc < 100 && exp_q.size() > 0; cyc++) begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].at_edge <= edge_cnt) begin
                e = exp_q.pop_front();
                checks++;
                if (e.at_edge != edge_cnt || obs !== e.vec) begin
                    errors++;
                    $display("FAIL %s: edge %0d got %b expected %b", e.name, edge_cnt, obs, e.vec);
                end
            end
            btn_raw = (edge_cnt >= 70 && edge_cnt < 73) || (edge_cnt >= 99 && edge_cnt < 139);
        end
        btn_raw = 1'b0;
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL btn_timeout: %0d expectations left", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_req_in_core();
        exp_t e;
        want(150, HOLD_SW, "core_req_hold_150");
        want(166, CORE_SW, "core_req_core_166");
        want(168, CORE_SW, "core_req_core_168");
        want(169, HOLD_SW, "core_req_reassert_169");
        want(184, HOLD_SW, "core_req_hold_184");
        want(185, CORE_SW, "core_req_core_185");
        want(192, CORE_SW, "core_req_core_192");
        want(193, RUN_SW,  "core_req_run_193");
        for (int cyc = 0; cyc < 60 && exp_q.size() > 0; cyc++) begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].at_edge <= edge_cnt) begin
                e = exp_q.pop_front();
                checks++;
                if (e.at_edge != edge_cnt || obs !== e.vec) begin
                    errors++;
                    $display("FAIL %s: edge %0d got %b expected %b", e.name, edge_cnt, obs, e.vec);
                end
            end
            sw_req = (edge_cnt == 149) || (edge_cnt == 168);
        end
        sw_req = 1'b0;
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL core_req_timeout: %0d expectations left", exp_q.size());
            exp_q.delete();
        end
    endtask

    // The press is sampled from edge 200, so btn_evt fires at edge 205.
    // sw_req is high at that same edge.
    task automatic test_back_to_back();
        exp_t e;
        want(204, RUN_SW,   "simul_before_204");
        want(205, HOLD_BTN, "simul_hold_205");
        want(220, HOLD_BTN, "simul_hold_220");
        want(221, CORE_BTN, "simul_core_221");
        want(228, CORE_BTN, "simul_core_228");
        want(229, RUN_BTN,  "simul_run_229");
        for (int cyc = 0; cyc < 60 && exp_q.size() > 0; cyc++) begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].at_edge <= edge_cnt) begin
                e = exp_q.pop_front();
                checks++;
                if (e.at_edge != edge_cnt || obs !== e.vec) begin
                    errors++;
                    $display("FAIL %s: edge %0d got %b expected %b", e.name, edge_cnt, obs, e.vec);
                end
            end
            btn_raw = (edge_cnt >= 199 && edge_cnt < 209);
            sw_req  = (edge_cnt == 204);
        end
        btn_raw = 1'b0;
        sw_req  = 1'b0;
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL simul_timeout: %0d expectations left", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        want(240, HOLD_SW, "async_sw_hold_240");
        want(244, HOLD_SW, "async_sw_hold_244");
        for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].at_edge <= edge_cnt) begin
                e = exp_q.pop_front();
                checks++;
                if (e.at_edge != edge_cnt || obs !== e.vec) begin
                    errors++;
                    $display("FAIL %s: edge %0d got %b expected %b", e.name, edge_cnt, obs, e.vec);
                end
            end
            sw_req = (edge_cnt == 239);
        end
        sw_req = 1'b0;
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL async_pre_timeout: %0d expectations left", exp_q.size());
            exp_q.delete();
        end
        // The reset pulse sits between two rising edges.
        #1 reset = 1'b1;
        #1;
        checks++;
        if (obs !== HOLD_EXT) begin
            errors++;
            $display("FAIL async_immediate: got %b expected %b", obs, HOLD_EXT);
        end
        #1 reset = 1'b0;
        want(17, HOLD_EXT, "async_hold_17");
        want(18, CORE_EXT, "async_core_18");
        want(25, CORE_EXT, "async_core_25");
        want(26, RUN_EXT,  "async_run_26");
        for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].at_edge <= edge_cnt) begin
                e = exp_q.pop_front();
                checks++;
                if (e.at_edge != edge_cnt || obs !== e.vec) begin
                    errors++;
                    $display("FAIL %s: edge %0d got %b expected %b", e.name, edge_cnt, obs, e.vec);
                end
            end
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL async_post_timeout: %0d expectations left", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_sw_req();
        test_button();
        test_req_in_core();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
